// File: rtl/lapido_defs.sv
`default_nettype none
// ============================================================================
// Module      : lapido_defs
// Description : Shared core_lapido definitions: flag indices, the flags_q
//               bit ordering and branch condition encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package lapido_defs;

  // flags_q = {carry, negzero, overflow, neg, true, zero}
  localparam int FL_ZERO     = 0;
  localparam int FL_TRUE     = 1;
  localparam int FL_NEG      = 2;
  localparam int FL_OVERFLOW = 3;
  localparam int FL_NEGZERO  = 4;
  localparam int FL_CARRY    = 5;
  localparam int FLAGS_W     = 6;

  typedef enum logic [2:0] {
    COND_ALWAYS   = 3'd0,
    COND_ZERO     = 3'd1,
    COND_TRUE     = 3'd2,
    COND_NEG      = 3'd3,
    COND_OVERFLOW = 3'd4,
    COND_NEGZERO  = 3'd5,
    COND_CARRY    = 3'd6,
    COND_NEVER    = 3'd7
  } cond_e;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Combinational branch condition evaluation against flags_q.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
  import lapido_defs::*;
(
  input  logic [FLAGS_W-1:0] flags,
  input  logic [2:0]         cond_sel,
  output logic               cond
);

  always_comb begin
    cond = 1'b0;
    case (cond_sel)
      COND_ALWAYS:   cond = 1'b1;
      COND_ZERO:     cond = flags[FL_ZERO];
      COND_TRUE:     cond = flags[FL_TRUE];
      COND_NEG:      cond = flags[FL_NEG];
      COND_OVERFLOW: cond = flags[FL_OVERFLOW];
      COND_NEGZERO:  cond = flags[FL_NEGZERO];
      COND_CARRY:    cond = flags[FL_CARRY];
      COND_NEVER:    cond = 1'b0;
      default:       cond = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg
// Description : EX/MEM pipeline register with architectural flag register,
//               branch resolution, stall hold and flush bubble insertion.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_reg
  import lapido_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NFLAGS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W:0]   alu_res,
  input  logic [NFLAGS-1:0] alu_flags,
  input  logic              flag_wr_en,
  input  logic [2:0]        cond_sel,
  input  logic              is_branch,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_wr_en,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              stall,
  input  logic              flush,
  output logic              valid_out,
  output logic [DATA_W-1:0] res_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [REG_AW-1:0] rd_addr_out,
  output logic              reg_wr_en_out,
  output logic              mem_rd_out,
  output logic              mem_wr_out,
  output logic              branch_taken,
  output logic [NFLAGS:0]   flags_q
);

  logic              r_valid;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] r_store_data;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_reg_wr_en;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_branch_taken;
  logic [NFLAGS:0]   r_flags;
  logic              w_cond;

  // Evaluated on the pre-update flags so a flag writer never resolves itself
  cond_eval u_cond_eval (
    .flags    (r_flags),
    .cond_sel (cond_sel),
    .cond     (w_cond)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_res          <= '0;
      r_store_data   <= '0;
      r_rd_addr      <= '0;
      r_reg_wr_en    <= 1'b0;
      r_mem_rd       <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_branch_taken <= 1'b0;
      r_flags        <= '0;
    end else if (flush) begin
      // Bubble: data and flags are left untouched
      r_valid        <= 1'b0;
      r_reg_wr_en    <= 1'b0;
      r_mem_rd       <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_branch_taken <= 1'b0;
    end else if (!stall) begin
      r_valid        <= valid_in;
      r_res          <= alu_res[DATA_W-1:0];
      r_store_data   <= store_data;
      r_rd_addr      <= rd_addr;
      r_reg_wr_en    <= reg_wr_en & valid_in;
      r_mem_rd       <= mem_rd & valid_in;
      r_mem_wr       <= mem_wr & valid_in;
      r_branch_taken <= valid_in & is_branch & w_cond;
      if (valid_in && flag_wr_en) begin
        r_flags <= {alu_res[DATA_W], alu_flags};
      end
    end
  end

  assign valid_out      = r_valid;
  assign res_out        = r_res;
  assign store_data_out = r_store_data;
  assign rd_addr_out    = r_rd_addr;
  assign reg_wr_en_out  = r_reg_wr_en;
  assign mem_rd_out     = r_mem_rd;
  assign mem_wr_out     = r_mem_wr;
  assign branch_taken   = r_branch_taken;
  assign flags_q        = r_flags;

  // A simultaneous load and store is passed through but never legal
  a_no_rd_wr : assert property (@(posedge clk) disable iff (rst)
                                !(valid_in && mem_rd && mem_wr));

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_reg
// Description : Directed-vector scoreboard bench for ex_mem_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_reg;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [32:0] alu_res;
  logic [4:0]  alu_flags;
  logic        flag_wr_en;
  logic [2:0]  cond_sel;
  logic        is_branch;
  logic [31:0] store_data;
  logic [4:0]  rd_addr;
  logic        reg_wr_en;
  logic        mem_rd;
  logic        mem_wr;
  logic        stall;
  logic        flush;
  logic        valid_out;
  logic [31:0] res_out;
  logic [31:0] store_data_out;
  logic [4:0]  rd_addr_out;
  logic        reg_wr_en_out;
  logic        mem_rd_out;
  logic        mem_wr_out;
  logic        branch_taken;
  logic [5:0]  flags_q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        bt;
    logic [5:0]  flags;
  } exp_t;

  exp_t sb[$];

  ex_mem_reg dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .alu_res        (alu_res),
    .alu_flags      (alu_flags),
    .flag_wr_en     (flag_wr_en),
    .cond_sel       (cond_sel),
    .is_branch      (is_branch),
    .store_data     (store_data),
    .rd_addr        (rd_addr),
    .reg_wr_en      (reg_wr_en),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .stall          (stall),
    .flush          (flush),
    .valid_out      (valid_out),
    .res_out        (res_out),
    .store_data_out (store_data_out),
    .rd_addr_out    (rd_addr_out),
    .reg_wr_en_out  (reg_wr_en_out),
    .mem_rd_out     (mem_rd_out),
    .mem_wr_out     (mem_wr_out),
    .branch_taken   (branch_taken),
    .flags_q        (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle, so one expectation per cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.tag, "valid_out",      32'(valid_out),      32'(e.valid));
      chk(e.tag, "res_out",        res_out,             e.res);
      chk(e.tag, "store_data_out", store_data_out,      e.sd);
      chk(e.tag, "rd_addr_out",    32'(rd_addr_out),    32'(e.rd));
      chk(e.tag, "reg_wr_en_out",  32'(reg_wr_en_out),  32'(e.rw));
      chk(e.tag, "mem_rd_out",     32'(mem_rd_out),     32'(e.mr));
      chk(e.tag, "mem_wr_out",     32'(mem_wr_out),     32'(e.mw));
      chk(e.tag, "branch_taken",   32'(branch_taken),   32'(e.bt));
      chk(e.tag, "flags_q",        32'(flags_q),        32'(e.flags));
    end
  end

  task automatic drive(input logic v, input logic [32:0] res, input logic [4:0] fl,
                       input logic fwe, input logic [2:0] cs, input logic br,
                       input logic [31:0] sd, input logic [4:0] rd, input logic rwe,
                       input logic mr, input logic mw, input logic st, input logic fsh);
    valid_in   = v;
    alu_res    = res;
    alu_flags  = fl;
    flag_wr_en = fwe;
    cond_sel   = cs;
    is_branch  = br;
    store_data = sd;
    rd_addr    = rd;
    reg_wr_en  = rwe;
    mem_rd     = mr;
    mem_wr     = mw;
    stall      = st;
    flush      = fsh;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] res,
                            input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                            input logic mr, input logic mw, input logic bt,
                            input logic [5:0] fl);
    exp_t e;
    e.tag = tag; e.valid = v; e.res = res; e.sd = sd; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.bt = bt; e.flags = fl;
    sb.push_back(e);
  endtask

  // Condition sweep against flags_q = 6'b100100 (carry, neg)
  logic [7:0] sweep_taken;

  initial begin
    sweep_taken = 8'b0100_1001;  // bit i = expected branch_taken for cond_sel i
    rst = 1'b1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 33'($urandom), 5'($urandom), 1'($urandom), 3'($urandom),
            1'($urandom), $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
    end
    rst = 1'b0;

    // Capture: carry from alu_res[32], flags 10001
    drive(1, 33'h1_0000_0000, 5'b10001, 1, 3'd0, 0, 32'hCAFE_0001, 5'd7, 1, 0, 0, 0, 0);
    expect_out("capture", 1, 32'h0, 32'hCAFE_0001, 5'd7, 1, 0, 0, 0, 6'b110001);

    // Stall three cycles with a new flag writer on the inputs
    for (int i = 0; i < 3; i++) begin
      drive(1, 33'h5, 5'b00010, 1, 3'd0, 0, 32'h0000_1234, 5'd9, 1, 0, 0, 1, 0);
      expect_out("stall", 1, 32'h0, 32'hCAFE_0001, 5'd7, 1, 0, 0, 0, 6'b110001);
    end

    // Release
    drive(1, 33'h5, 5'b00010, 1, 3'd0, 0, 32'h0000_1234, 5'd9, 1, 0, 0, 0, 0);
    expect_out("release", 1, 32'h5, 32'h0000_1234, 5'd9, 1, 0, 0, 0, 6'b000010);

    // Flush wins over stall; data held, flags not updated
    drive(1, 33'h1_FFFF_FFFF, 5'b11111, 1, 3'd0, 1, 32'h0000_AAAA, 5'd3, 0, 0, 1, 1, 1);
    expect_out("flush", 0, 32'h5, 32'h0000_1234, 5'd9, 0, 0, 0, 0, 6'b000010);

    // Flag writer branching on zero sees the old zero=0
    drive(1, 33'h0, 5'b00001, 1, 3'd1, 1, 32'h0, 5'd0, 0, 0, 0, 0, 0);
    expect_out("br_self", 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 6'b000001);

    // Next branch sees zero=1
    drive(1, 33'h42, 5'b00000, 0, 3'd1, 1, 32'h0, 5'd0, 0, 0, 0, 0, 0);
    expect_out("br_next", 1, 32'h42, 32'h0, 5'd0, 0, 0, 0, 1, 6'b000001);

    // Load passes mem_rd through
    drive(1, 33'h100, 5'b00000, 0, 3'd0, 0, 32'h0, 5'd12, 1, 1, 0, 0, 0);
    expect_out("load", 1, 32'h100, 32'h0, 5'd12, 1, 1, 0, 0, 6'b000001);

    // Preload flags 100100
    drive(1, 33'h1_0000_0000, 5'b00100, 1, 3'd0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0);
    expect_out("preload", 1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 6'b100100);

    for (int c = 0; c < 8; c++) begin
      drive(1, 33'(c), 5'b00000, 0, 3'(c), 1, 32'h0, 5'd0, 0, 0, 0, 0, 0);
      expect_out($sformatf("sweep%0d", c), 1, 32'(c), 32'h0, 5'd0, 0, 0, 0,
                 sweep_taken[c], 6'b100100);
    end

    // valid_in=0: controls gated, data still captured
    for (int c = 0; c < 8; c++) begin
      drive(0, 33'(c + 16), 5'b11111, 1, 3'(c), 1, 32'h0000_00F0, 5'd4, 1, 1, 0, 0, 0);
      expect_out($sformatf("invalid%0d", c), 0, 32'(c + 16), 32'h0000_00F0, 5'd4, 0, 0, 0,
                 0, 6'b100100);
    end

    // Store then reset while stalled
    drive(1, 33'h1_0000_0077, 5'b01010, 1, 3'd0, 1, 32'h5555_0000, 5'd2, 0, 0, 1, 0, 0);
    expect_out("store", 1, 32'h77, 32'h5555_0000, 5'd2, 0, 0, 1, 1, 6'b101010);
    rst = 1'b1;
    drive(1, 33'h1_0000_0077, 5'b01010, 1, 3'd0, 1, 32'h5555_0000, 5'd2, 0, 0, 1, 1, 0);
    expect_out("rst_stall", 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
    rst = 1'b0;
    drive(0, 33'h0, 5'b00000, 0, 3'd0, 0, 32'h0, 5'd0, 0, 0, 0, 0, 0);
    expect_out("idle", 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
